// File: rtl/wb_master_cmd_if.sv
// Command, response and Wishbone classic signals of the command-driven bus master.
// The master modport is the block's view; slave is the view of whoever drives commands and serves the bus.
interface wb_master_cmd_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4
) ();
  logic [ADDR_WIDTH-1:0]   cmd_adr;
  logic [DATA_WIDTH-1:0]   cmd_dat;
  logic [SELECT_WIDTH-1:0] cmd_sel;
  logic                    cmd_we;
  logic                    cmd_valid;
  logic                    cmd_ready;

  logic [DATA_WIDTH-1:0]   rsp_dat;
  logic [1:0]              rsp_status;
  logic                    rsp_valid;
  logic                    rsp_ready;

  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic                    wb_we_o;
  logic [SELECT_WIDTH-1:0] wb_sel_o;
  logic                    wb_stb_o;
  logic                    wb_cyc_o;
  logic                    wb_ack_i;
  logic                    wb_err_i;

  modport master (
    input  cmd_adr, cmd_dat, cmd_sel, cmd_we, cmd_valid,
    output cmd_ready,
    output rsp_dat, rsp_status, rsp_valid,
    input  rsp_ready,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output cmd_adr, cmd_dat, cmd_sel, cmd_we, cmd_valid,
    input  cmd_ready,
    input  rsp_dat, rsp_status, rsp_valid,
    output rsp_ready,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_master_cmd.sv
// Turns one command into one Wishbone classic cycle and returns data/status (OK, bus error, timeout).
// Registered-ack slave: accept at N, ack sampled N+2, response valid from N+2; response holds until rsp_ready.
module wb_master_cmd #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4,
  parameter int TIMEOUT      = 255
) (
  input logic clk,
  input logic rst_n,
  wb_master_cmd_if.master bus
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW:0] TLIM = (TW + 1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                  state_q;
  logic                    cmd_ready_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [SELECT_WIDTH-1:0] sel_q;
  logic                    we_q;
  logic                    cyc_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_dat_q;
  logic [1:0]              rsp_status_q;
  logic [TW-1:0]           timer_q;
  logic [TW-1:0]           timer_d;
  logic                    timeout_hit_d;

  // Timer saturates so a disabled timeout can never wrap into a false expiry.
  assign timer_d       = (&timer_q) ? timer_q : timer_q + 1'b1;
  assign timeout_hit_d = (TIMEOUT != 0) && (({1'b0, timer_q} + 1'b1) == TLIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= 2'b00;
      timer_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            adr_q       <= bus.cmd_adr;
            dat_q       <= bus.cmd_dat;
            sel_q       <= bus.cmd_sel;
            we_q        <= bus.cmd_we;
            cyc_q       <= 1'b1;
            timer_q     <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= BUS;
          end
        end
        BUS: begin
          // Error outranks ack; either outranks a timeout landing on the same edge.
          if (bus.wb_err_i) begin
            rsp_dat_q    <= '0;
            rsp_status_q <= 2'b01;
            cyc_q        <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else if (bus.wb_ack_i) begin
            rsp_dat_q    <= we_q ? '0 : bus.wb_dat_i;
            rsp_status_q <= 2'b00;
            cyc_q        <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else if (timeout_hit_d) begin
            rsp_dat_q    <= '0;
            rsp_status_q <= 2'b10;
            cyc_q        <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            timer_q <= timer_d;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          cyc_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_dat    = rsp_dat_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.wb_adr_o   = adr_q;
  assign bus.wb_dat_o   = dat_q;
  assign bus.wb_sel_o   = sel_q;
  assign bus.wb_we_o    = we_q;
  assign bus.wb_cyc_o   = cyc_q;
  assign bus.wb_stb_o   = cyc_q;
endmodule

// File: tb/tb_wb_master_cmd.sv
// Random commands against a memory-backed Wishbone slave with programmable wait/error per cycle;
// expected responses and bus cycles come from a memory model and the slave's chosen answer time.
module tb_wb_master_cmd;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_master_cmd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) bus ();
  wb_master_cmd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) bus0 ();

  wb_master_cmd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(TO))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  wb_master_cmd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  typedef struct { logic [31:0] dat; logic [1:0] st; } rsp_t;
  typedef struct { logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; int len; } cyc_t;
  typedef struct { int delay; bit err; } slv_t;

  rsp_t rsp_q[$];
  cyc_t cyc_q[$];
  slv_t slv_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  int vectors = 0;
  int miscompares = 0;
  bit bp_hold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) if (sel[b]) m[8*b +: 8] = nw[8*b +: 8];
    return m;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] adr);
    return ref_mem.exists(adr) ? ref_mem[adr] : 32'h0;
  endfunction

  // Reference: the slave answers on BUS cycle delay+2; anything later than TO cycles is a timeout.
  task automatic issue(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int delay, input bit err);
    rsp_t r;
    cyc_t c;
    int resp_at;
    int guard;
    resp_at = delay + 2;
    c.adr = adr; c.we = we; c.sel = sel; c.dat = dat;
    r.dat = 32'h0;
    if (TO != 0 && resp_at > TO) begin
      r.st = 2'b10; c.len = TO;
    end else if (err) begin
      r.st = 2'b01; c.len = resp_at;
    end else begin
      r.st = 2'b00; c.len = resp_at;
      if (we) ref_mem[adr] = merge(ref_rd(adr), dat, sel);
      else r.dat = ref_rd(adr);
    end
    slv_q.push_back('{delay, err});
    rsp_q.push_back(r);
    cyc_q.push_back(c);
    @(negedge clk);
    bus.cmd_we = we; bus.cmd_adr = adr; bus.cmd_dat = dat; bus.cmd_sel = sel; bus.cmd_valid = 1'b1;
    guard = 0;
    while (!bus.cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_accept_timeout", 64'(guard == 200), 64'(0));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_adr = $urandom; bus.cmd_dat = $urandom; bus.cmd_sel = 4'($urandom); bus.cmd_we = 1'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((rsp_q.size() != 0 || bus.rsp_valid || bus.wb_cyc_o) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 64'(guard == 500), 64'(0));
  endtask

  // Slave: counts cycles of an active strobe and answers on the chosen one; idle-time junk on ack/err.
  initial begin
    int cnt;
    slv_t cur;
    cnt = 0;
    cur = '{1000, 1'b0};
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
      end else if (bus.wb_cyc_o && bus.wb_stb_o) begin
        if (cnt == 0) cur = (slv_q.size() != 0) ? slv_q.pop_front() : '{1000, 1'b0};
        cnt++;
        if (cnt == cur.delay + 2) begin
          bus.wb_err_i = cur.err;
          bus.wb_ack_i = cur.err ? 1'($urandom) : 1'b1;
          bus.wb_dat_i = slv_mem.exists(bus.wb_adr_o) ? slv_mem[bus.wb_adr_o] : 32'h0;
          if (!cur.err && bus.wb_we_o) begin
            slv_mem[bus.wb_adr_o] = merge(bus.wb_dat_i, bus.wb_dat_o, bus.wb_sel_o);
          end
        end else begin
          bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = $urandom;
        end
      end else begin
        cnt = 0;
        bus.wb_ack_i = ($urandom_range(0, 3) == 0);
        bus.wb_err_i = ($urandom_range(0, 7) == 0);
        bus.wb_dat_i = $urandom;
      end
    end
  end

  // Response monitor: picks rsp_ready, then scores the handshake the next edge will complete.
  initial begin
    bit held;
    logic [31:0] pdat;
    logic [1:0] pst;
    rsp_t e;
    held = 1'b0; pdat = '0; pst = '0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (rst_n && bus.rsp_valid) begin
        check("cmd_ready_during_rsp", 64'(bus.cmd_ready), 64'(0));
        if (held) begin
          check("rsp_dat_stable", 64'(bus.rsp_dat), 64'(pdat));
          check("rsp_status_stable", 64'(bus.rsp_status), 64'(pst));
        end
        if (bus.rsp_ready) begin
          if (rsp_q.size() == 0) begin
            check("unexpected_rsp", 64'(1), 64'(0));
          end else begin
            e = rsp_q.pop_front();
            check("rsp_dat", 64'(bus.rsp_dat), 64'(e.dat));
            check("rsp_status", 64'(bus.rsp_status), 64'(e.st));
          end
          held = 1'b0;
        end else begin
          held = 1'b1; pdat = bus.rsp_dat; pst = bus.rsp_status;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // Bus-cycle monitor: one cycle per command, fields match the command, length matches the answer time.
  initial begin
    int ccnt;
    cyc_t ccur;
    ccnt = 0;
    ccur = '{32'h0, 1'b0, 4'h0, 32'h0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ccnt = 0;
      end else if (bus.wb_cyc_o) begin
        if (ccnt == 0) begin
          if (cyc_q.size() == 0) check("unexpected_cyc", 64'(1), 64'(0));
          else ccur = cyc_q.pop_front();
        end
        ccnt++;
        check("wb_stb", 64'(bus.wb_stb_o), 64'(1));
        check("wb_adr", 64'(bus.wb_adr_o), 64'(ccur.adr));
        check("wb_we", 64'(bus.wb_we_o), 64'(ccur.we));
        check("wb_sel", 64'(bus.wb_sel_o), 64'(ccur.sel));
        if (ccur.we) check("wb_dat_o", 64'(bus.wb_dat_o), 64'(ccur.dat));
      end else if (ccnt > 0) begin
        check("cyc_len", 64'(ccnt), 64'(ccur.len));
        check("stb_drop", 64'(bus.wb_stb_o), 64'(0));
        ccnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int guard;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_adr = '0; bus.cmd_dat = '0; bus.cmd_sel = '0; bus.cmd_we = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_adr = '0; bus0.cmd_dat = '0; bus0.cmd_sel = '0; bus0.cmd_we = 1'b0;
    bus0.rsp_ready = 1'b1; bus0.wb_ack_i = 1'b0; bus0.wb_err_i = 1'b0; bus0.wb_dat_i = '0;
    #12;
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    check("rst_cyc", 64'(bus.wb_cyc_o), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_adr", 64'(bus.wb_adr_o), 64'(0));
    check("rst_rsp_status", 64'(bus.rsp_status), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("cmd_ready_after_rst", 64'(bus.cmd_ready), 64'(1));

    // Write then read with zero-wait slave.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0);
    drain();
    // Byte-lane write over zero.
    issue(1'b1, 32'h20, 32'h0, 4'hF, 0, 1'b0);
    issue(1'b1, 32'h20, 32'h11223344, 4'h2, 0, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 4'hF, 1, 1'b0);
    drain();
    // Bus error on the third BUS cycle, then a timeout, then ack on the timeout cycle itself.
    issue(1'b0, 32'h10, 32'h0, 4'hF, 1, 1'b1);
    issue(1'b1, 32'h10, 32'h55555555, 4'hF, 7, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'hF, TO - 2, 1'b0);
    drain();
    // Backpressure with the next command already waiting.
    bp_hold = 1'b1;
    fork
      begin repeat (10) @(negedge clk); bp_hold = 1'b0; end
    join_none
    issue(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0);
    issue(1'b1, 32'h24, 32'hCAFEF00D, 4'hC, 0, 1'b0);
    drain();

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        bp_hold = 1'b1;
        fork
          begin repeat (6) @(negedge clk); bp_hold = 1'b0; end
        join_none
      end
      issue(1'($urandom), {27'h0, 3'($urandom_range(0, 7)), 2'b00}, $urandom, 4'($urandom),
            $urandom_range(0, 5), ($urandom_range(0, 5) == 0));
    end
    drain();

    // Reset in the middle of a bus cycle.
    issue(1'b1, 32'h40, 32'h12345678, 4'hF, 20, 1'b0);
    guard = 0;
    while (!bus.wb_cyc_o && guard < 20) begin @(negedge clk); guard++; end
    check("cyc_before_reset", 64'(bus.wb_cyc_o), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cyc", 64'(bus.wb_cyc_o), 64'(0));
    check("async_rst_stb", 64'(bus.wb_stb_o), 64'(0));
    check("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("async_rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    rsp_q.delete();
    cyc_q.delete();
    slv_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'hF, 2, 1'b0);
    drain();

    // Timeout disabled: the cycle must stay open indefinitely.
    @(negedge clk);
    bus0.cmd_adr = 32'h80; bus0.cmd_we = 1'b0; bus0.cmd_sel = 4'hF; bus0.cmd_valid = 1'b1;
    guard = 0;
    while (!bus0.cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    check("t0_accept", 64'(bus0.cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    bus0.cmd_valid = 1'b0;
    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus0.wb_cyc_o && bus0.wb_stb_o) hi++;
    end
    check("t0_cyc_held", 64'(hi), 64'(1000));
    check("t0_no_rsp", 64'(bus0.rsp_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_master_cmd.md
WB_MASTER_CMD -- requirements
Module: wb_master_cmd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (8, 16, 32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 SHALL have parameter SELECT_WIDTH, default 4, byte select width, DATA_WIDTH/8.
REQ-004 SHALL have parameter TIMEOUT, default 255, max bus-wait cycles before abort; 0 disables the timeout.
REQ-005 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: cmd_adr  in  ADDR_WIDTH, cmd_dat  in  DATA_WIDTH, cmd_sel  in  SELECT_WIDTH, cmd_we  in  1  (command fields).
REQ-008 SHALL have ports: cmd_valid  in  1, cmd_ready  out  1  (command handshake).
REQ-009 SHALL have ports: rsp_dat  out  DATA_WIDTH  read data; rsp_status  out  2  (00 OK, 01 bus error, 10 timeout).
REQ-010 SHALL have ports: rsp_valid  out  1, rsp_ready  in  1  (response handshake).
REQ-011 SHALL have ports: wb_adr_o  out  ADDR_WIDTH, wb_dat_o  out  DATA_WIDTH, wb_dat_i  in  DATA_WIDTH, wb_we_o  out  1, wb_sel_o  out  SELECT_WIDTH, wb_stb_o  out  1, wb_cyc_o  out  1, wb_ack_i  in  1, wb_err_i  in  1  (Wishbone classic master).

Function
REQ-012 SHALL implement states IDLE, BUS, RESP; all outputs registered.
REQ-013 SHALL assert cmd_ready only in IDLE; command accepted on edge where cmd_valid & cmd_ready.
REQ-014 SHALL on acceptance latch cmd fields onto wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o, set wb_cyc_o = wb_stb_o = 1, clear timer, enter BUS (cyc/stb visible the cycle after acceptance).
REQ-015 SHALL hold all wb_*_o outputs stable throughout BUS.
REQ-016 SHALL in BUS, on sampling wb_ack_i = 1: capture wb_dat_i into rsp_dat if read (rsp_dat = 0 if write), rsp_status = 00, drop wb_cyc_o and wb_stb_o on the same edge, enter RESP.
REQ-017 SHALL in BUS, on sampling wb_err_i = 1: rsp_dat = 0, rsp_status = 01, drop cyc/stb, enter RESP; if ack and err are sampled together, err wins.
REQ-018 SHALL count BUS cycles without ack/err; when TIMEOUT != 0 and count reaches TIMEOUT: rsp_dat = 0, rsp_status = 10, drop cyc/stb, enter RESP.
REQ-019 SHALL size the timer to hold TIMEOUT without wrap; timer saturates and is unused when TIMEOUT = 0 (bus waits indefinitely).
REQ-020 SHALL assert rsp_valid throughout RESP with rsp_dat/rsp_status stable until rsp_valid & rsp_ready, then return to IDLE.
REQ-021 SHALL ignore wb_ack_i and wb_err_i outside BUS.
REQ-022 SHALL drive wb_cyc_o = wb_stb_o = 1 for exactly one bus transaction per command; no back-to-back cycles (minimum one idle cycle between transactions).
REQ-023 SHALL achieve latency with a registered-ack slave: accept at edge N, cyc high N..N+1, ack sampled N+2, rsp_valid high from N+2 edge; cmd_ready high again the cycle after response handshake.

Reset
REQ-024 SHALL on rst_n = 0 immediately (asynchronously) force state IDLE, wb_cyc_o = wb_stb_o = wb_we_o = 0, wb_adr_o/wb_dat_o/wb_sel_o = 0, rsp_valid = 0, rsp_dat = 0, rsp_status = 00, timer = 0.
REQ-025 SHALL drive cmd_ready = 0 while rst_n = 0 and 1 from the first clock edge after rst_n deasserts.
REQ-026 SHALL abandon any in-flight command or pending response on reset without producing a response.

Verification
REQ-027 Write then read: cmd write adr 0x10, dat 0xDEADBEEF, sel 0xF to zero-wait registered-ack slave -> rsp_status 00, rsp_dat 0; then read adr 0x10 -> rsp_dat 0xDEADBEEF, cyc high exactly 2 cycles each.
REQ-028 Byte select: write 0x11223344 sel 0x2 over 0x00000000 then read -> rsp_dat 0x00003300; wb_sel_o = 0x2 for write cycle.
REQ-029 Bus error: slave asserts wb_err_i (with ack) on 3rd BUS cycle -> rsp_status 01, rsp_dat 0, cyc/stb low next cycle.
REQ-030 Timeout: TIMEOUT = 4, slave never responds -> cyc/stb high 4 cycles then low, rsp_status 10; with TIMEOUT = 0, cyc stays high 1000 cycles.
REQ-031 Backpressure: rsp_ready low 5 cycles -> rsp_valid and rsp_dat stable, cmd_ready low, cmd_valid held ignored until handshake.
REQ-032 Reset mid-operation: drop rst_n while cyc high -> cyc/stb/rsp_valid low without clock edge; after release, next command completes normally with no stale response.
